// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port memory.
// It allows one outstanding transaction and aborts a transaction with a timeout error if it runs too long.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [63:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_wen,
   input  logic [63:0] ls_addr,
   input  logic [63:0] ls_wdata,
   input  logic [7:0]  ls_wmask,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [63:0] ls_rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_wen,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata
);

   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;
   localparam int unsigned MW = 8;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t          state, state_nxt;
   logic            rr_last_ls;
   logic            owner_ls;
   logic [CW-1:0]   cnt;
   logic            wen_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [MW-1:0]   wmask_q;
   logic            grant_if, grant_ls;
   logic            timeout, done_mem, respond;

   // Arbitration: on a tie, the requester not served last wins; no grant while reset is held.
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (rst && state == S_IDLE) begin
         grant_if = if_req && (!ls_req || rr_last_ls);
         grant_ls = ls_req && (!if_req || !rr_last_ls);
      end
   end

   assign timeout  = (state != S_IDLE) && (cnt == CW'(TIMEOUT - 1));
   assign done_mem = (state == S_RESP) && mem_rvalid;
   assign respond  = rst && (done_mem || timeout);

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (grant_if || grant_ls) state_nxt = S_REQ;
         S_REQ: begin
            if (timeout)        state_nxt = S_IDLE;
            else if (mem_ready) state_nxt = S_RESP;
         end
         S_RESP: if (mem_rvalid || timeout) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Latched request, owner, round-robin pointer and timeout counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_last_ls <= 1'b1;
         owner_ls   <= 1'b0;
         cnt        <= '0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
      end else if (grant_if) begin
         rr_last_ls <= 1'b0;
         owner_ls   <= 1'b0;
         cnt        <= '0;
         wen_q      <= 1'b0;
         addr_q     <= if_addr;
         wdata_q    <= '0;
         wmask_q    <= '0;
      end else if (grant_ls) begin
         rr_last_ls <= 1'b1;
         owner_ls   <= 1'b1;
         cnt        <= '0;
         wen_q      <= ls_wen;
         addr_q     <= ls_addr;
         wdata_q    <= ls_wdata;
         wmask_q    <= ls_wmask;
      end else if (state != S_IDLE) begin
         cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      if_gnt    = grant_if;
      ls_gnt    = grant_ls;
      mem_req   = (state == S_REQ);
      mem_wen   = wen_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_wmask = wmask_q;
      if_rvalid = 1'b0;
      ls_rvalid = 1'b0;
      if_rdata  = '0;
      ls_rdata  = '0;
      err       = 1'b0;
      // A memory completion takes priority over a timeout in the same cycle.
      if (respond) begin
         err = !done_mem;
         if (owner_ls) begin
            ls_rvalid = 1'b1;
            if (done_mem && !wen_q) ls_rdata = mem_rdata;
         end else begin
            if_rvalid = 1'b1;
            if (done_mem) if_rdata = mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with TIMEOUT=8.
// It covers grant and response timing, round-robin ties, backpressure, timeout, and reset mid-transaction.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [63:0] if_addr, if_rdata;
   logic        ls_req, ls_wen, ls_gnt, ls_rvalid;
   logic [63:0] ls_addr, ls_wdata, ls_rdata;
   logic [7:0]  ls_wmask;
   logic        err, mem_req, mem_wen, mem_ready, mem_rvalid;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .err(err), .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nx;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; if_req = 1'b1; if_addr = '0; ls_req = 1'b1; ls_wen = 1'b0;
      ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      nx; nx;
      @(negedge clk);
      chk("rst_if_gnt", 64'(if_gnt), 0);
      chk("rst_ls_gnt", 64'(ls_gnt), 0);
      chk("rst_mem_req", 64'(mem_req), 0);
      chk("rst_mem_addr", mem_addr, 0);
      nx;
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0;

      // Single fetch
      if_req = 1'b1; if_addr = 64'h8000_0000;
      @(negedge clk);
      chk("f_if_gnt", 64'(if_gnt), 1);
      chk("f_ls_gnt", 64'(ls_gnt), 0);
      nx;
      if_req = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      chk("f_mem_req", 64'(mem_req), 1);
      chk("f_mem_addr", mem_addr, 64'h8000_0000);
      chk("f_mem_wen", 64'(mem_wen), 0);
      chk("f_gnt_again", 64'(if_gnt), 0);
      nx;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("f_resp_mem_req", 64'(mem_req), 0);
      chk("f_early_rvalid", 64'(if_rvalid), 0);
      nx;
      mem_rvalid = 1'b1; mem_rdata = 64'h13;
      @(negedge clk);
      chk("f_if_rvalid", 64'(if_rvalid), 1);
      chk("f_if_rdata", if_rdata, 64'h13);
      chk("f_ls_rvalid", 64'(ls_rvalid), 0);
      chk("f_err", 64'(err), 0);
      nx;
      @(negedge clk);
      chk("idle_rvalid_ignored", 64'(if_rvalid), 0);
      chk("idle_rdata_zero", if_rdata, 0);
      nx;
      mem_rvalid = 1'b0;

      // Store
      ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_0100;
      ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
      @(negedge clk);
      chk("s_ls_gnt", 64'(ls_gnt), 1);
      chk("s_if_gnt", 64'(if_gnt), 0);
      nx;
      ls_req = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      chk("s_mem_req", 64'(mem_req), 1);
      chk("s_mem_wen", 64'(mem_wen), 1);
      chk("s_mem_addr", mem_addr, 64'h8000_0100);
      chk("s_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
      chk("s_mem_wmask", 64'(mem_wmask), 64'h0F);
      nx;
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678;
      @(negedge clk);
      chk("s_ls_rvalid", 64'(ls_rvalid), 1);
      chk("s_ls_rdata", ls_rdata, 0);
      chk("s_if_rvalid", 64'(if_rvalid), 0);
      nx;
      mem_rvalid = 1'b0;

      // Tie after reset: IF, LS, IF, LS
      rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_wen = 1'b0;
      if_addr = 64'h100; ls_addr = 64'h200;
      nx;
      rst = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h55;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("tie_if_gnt_%0d", c), 64'(if_gnt), 64'(c % 6 == 0));
         chk($sformatf("tie_ls_gnt_%0d", c), 64'(ls_gnt), 64'(c % 6 == 3));
         chk($sformatf("tie_if_rv_%0d", c), 64'(if_rvalid), 64'(c % 6 == 2));
         chk($sformatf("tie_ls_rv_%0d", c), 64'(ls_rvalid), 64'(c % 6 == 5));
         if (c % 6 == 5) chk($sformatf("tie_ls_rdata_%0d", c), ls_rdata, 64'h55);
         nx;
      end
      if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;

      // Backpressure on a store with mem_rvalid noise before acceptance
      ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 64'h40; ls_wdata = 64'hCAFE; ls_wmask = 8'hFF;
      @(negedge clk);
      chk("bp_ls_gnt", 64'(ls_gnt), 1);
      nx;
      ls_req = 1'b0; if_req = 1'b1; if_addr = 64'h9000; mem_rvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_mem_req_%0d", i), 64'(mem_req), 1);
         chk($sformatf("bp_mem_addr_%0d", i), mem_addr, 64'h40);
         chk($sformatf("bp_mem_wdata_%0d", i), mem_wdata, 64'hCAFE);
         chk($sformatf("bp_if_gnt_%0d", i), 64'(if_gnt), 0);
         chk($sformatf("bp_ls_rvalid_%0d", i), 64'(ls_rvalid), 0);
         nx;
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_mem_req", 64'(mem_req), 1);
      nx;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("bp_ls_rvalid", 64'(ls_rvalid), 1);
      chk("bp_ls_rdata", ls_rdata, 0);
      chk("bp_if_gnt_resp", 64'(if_gnt), 0);
      nx;

      // Timeout on the pending fetch
      mem_rvalid = 1'b0; mem_rdata = 64'h77;
      @(negedge clk);
      chk("to_if_gnt", 64'(if_gnt), 1);
      nx;
      if_req = 1'b0;
      @(negedge clk);
      chk("to_mem_wen", 64'(mem_wen), 0);
      chk("to_mem_wmask", 64'(mem_wmask), 0);
      chk("to_mem_addr", mem_addr, 64'h9000);
      nx;
      for (int i = 2; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("to_err_early_%0d", i), 64'(err), 0);
         chk($sformatf("to_rv_early_%0d", i), 64'(if_rvalid), 0);
         nx;
      end
      @(negedge clk);
      chk("to_if_rvalid", 64'(if_rvalid), 1);
      chk("to_err", 64'(err), 1);
      chk("to_if_rdata", if_rdata, 0);
      chk("to_ls_rvalid", 64'(ls_rvalid), 0);
      nx;
      @(negedge clk);
      chk("to_after_err", 64'(err), 0);
      chk("to_after_mem_req", 64'(mem_req), 0);
      nx;

      // mem_rvalid arriving on the timeout cycle wins
      if_req = 1'b1; if_addr = 64'hA000;
      @(negedge clk);
      chk("tr_if_gnt", 64'(if_gnt), 1);
      nx;
      if_req = 1'b0; mem_ready = 1'b1;
      nx;
      mem_ready = 1'b0;
      for (int i = 2; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("tr_rv_early_%0d", i), 64'(if_rvalid), 0);
         nx;
      end
      mem_rvalid = 1'b1; mem_rdata = 64'h99;
      @(negedge clk);
      chk("tr_if_rvalid", 64'(if_rvalid), 1);
      chk("tr_err", 64'(err), 0);
      chk("tr_if_rdata", if_rdata, 64'h99);
      nx;
      mem_rvalid = 1'b0;

      // Reset during RESP discards the response
      if_req = 1'b1; if_addr = 64'hB000;
      @(negedge clk);
      chk("rr_if_gnt", 64'(if_gnt), 1);
      nx;
      if_req = 1'b0; mem_ready = 1'b1;
      nx;
      mem_ready = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("rr_rvalid_in_rst", 64'(if_rvalid), 0);
      nx;
      rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h42;
      @(negedge clk);
      chk("rr_if_rvalid", 64'(if_rvalid), 0);
      chk("rr_mem_req", 64'(mem_req), 0);
      chk("rr_mem_addr", mem_addr, 0);
      chk("rr_err", 64'(err), 0);
      nx;
      mem_rvalid = 1'b0; ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 64'h300;
      @(negedge clk);
      chk("rr_ls_gnt", 64'(ls_gnt), 1);
      nx;
      ls_req = 1'b0;
      @(negedge clk);
      chk("rr_ls_mem_addr", mem_addr, 64'h300);
      nx;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles one transaction may occupy the memory bus before it is aborted.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-low.
REQ-004 if_req  in  1  fetch requester wants a read; held with if_addr stable until if_gnt.
REQ-005 if_addr  in  64  fetch address.
REQ-006 if_gnt  out  1  one-cycle pulse: fetch request accepted this cycle.
REQ-007 if_rvalid  out  1  one-cycle pulse: fetch response on if_rdata.
REQ-008 if_rdata  out  64  fetch read data.
REQ-009 ls_req  in  1  load/store requester wants access; held with all ls_* inputs stable until ls_gnt.
REQ-010 ls_wen / ls_addr / ls_wdata / ls_wmask  in  1/64/64/8  write enable, address, write data, byte mask.
REQ-011 ls_gnt / ls_rvalid  out  1/1  accept pulse / response pulse for load/store.
REQ-012 ls_rdata  out  64  load data; 0 for writes.
REQ-013 err  out  1  one-cycle pulse with the aborted owner's rvalid on timeout.
REQ-014 mem_req  out  1  request to single-port memory.
REQ-015 mem_wen / mem_addr / mem_wdata / mem_wmask  out  1/64/64/8  latched request fields.
REQ-016 mem_ready  in  1  memory accepts mem_req this cycle.
REQ-017 mem_rvalid / mem_rdata  in  1/64  memory completion (reads and writes) and read data.

Function
REQ-018 FSM states: IDLE, REQ, RESP; exactly one transaction outstanding.
REQ-019 IDLE: if any request pending, the arbiter SHALL assert the winner's gnt combinationally, latch its fields and the owner, and move to REQ next cycle.
REQ-020 Winner: only one requesting -> that one; both requesting -> the one not served last (rr_last register, updated on every grant).
REQ-021 Fetch grants SHALL force mem_wen=0 and mem_wmask=0.
REQ-022 REQ: mem_req=1 with latched fields; on mem_ready go to RESP; otherwise hold.
REQ-023 RESP: mem_req=0; mem_rvalid sampled only here; on mem_rvalid the arbiter SHALL pulse the owner's rvalid in the same cycle, pass mem_rdata to the owner's rdata (ls_rdata=0 if write), and go to IDLE.
REQ-024 The arbiter SHALL ignore mem_rvalid in IDLE and REQ.
REQ-025 Non-owner rvalid SHALL be 0; rdata outputs SHALL be 0 when their rvalid is 0.
REQ-026 Latency: gnt at cycle N -> mem_req from N+1 -> at least one IDLE cycle after a response before the next gnt.
REQ-027 8-bit timeout counter SHALL clear on grant and count each cycle in REQ/RESP; on reaching TIMEOUT go to IDLE, pulse owner's rvalid and err, rdata=0.
REQ-028 Timeout and mem_rvalid in the same cycle: mem_rvalid wins; err=0.
REQ-029 Requests deasserted before gnt SHALL be dropped without side effects.

Reset
REQ-030 rst=0 at a clock edge: state=IDLE, rr_last=load/store (fetch wins first tie), counter=0, latched fields=0; all outputs 0 in the following cycle, including mid-transaction (the in-flight response is discarded).

Verification
REQ-031 Single fetch: if_req, if_addr=0x8000_0000; mem_ready next cycle; mem_rvalid 2 cycles later, rdata=0x13 -> if_gnt at N, mem_req N+1, if_rvalid with 0x13 at N+3.
REQ-032 Tie: both requesting continuously after reset -> grants alternate IF, LS, IF, LS.
REQ-033 Store: ls_wen=1, addr=0x8000_0100, wdata=0xDEAD_BEEF, wmask=0x0F -> identical mem_* fields; ls_rvalid with ls_rdata=0.
REQ-034 Backpressure: mem_ready low 5 cycles -> mem_req and fields held stable; no new gnt.
REQ-035 Timeout: TIMEOUT=8, mem_rvalid never -> owner rvalid + err at 8th cycle after gnt, then IDLE.
REQ-036 Reset in RESP, then mem_rvalid -> no rvalid output; next request is granted normally.
